// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-count debouncer and press/release pulses.
// Define BTN_AUTO_REPEAT_EN to re-pulse btn_press while a button is held.
module btn_debounce #(
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 1000000,
    parameter int REP_DELAY = 50000000,
    parameter int REP_RATE  = 10000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] led
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [NBTN-1:0] s1_q, s1_d;
    logic [NBTN-1:0] s2_q, s2_d;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] press_q, press_d;
    logic [NBTN-1:0] release_q, release_d;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] rep;

    always_comb begin
        s1_d      = btn;
        s2_d      = s1_q;
        level_d   = level_q;
        rise      = '0;
        release_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = s2_q[i];
                    rise[i]      = s2_q[i];
                    release_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] R_RATE  = RW'(REP_RATE - 1);
    localparam logic [RW-1:0] R_ONE   = RW'(1);

    logic [RW-1:0]   rcnt_q [NBTN];
    logic [RW-1:0]   rcnt_d [NBTN];
    logic [NBTN-1:0] rphase_q, rphase_d;

    // rphase selects between the initial delay and the steady repeat rate
    always_comb begin
        rep      = '0;
        rphase_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            rcnt_d[i] = '0;
            if (level_q[i] && level_d[i]) begin
                rphase_d[i] = rphase_q[i];
                if (rcnt_q[i] == (rphase_q[i] ? R_RATE : R_DELAY)) begin
                    rep[i]      = 1'b1;
                    rphase_d[i] = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + R_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rphase_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            rphase_q <= rphase_d;
            for (int i = 0; i < NBTN; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end
`else
    logic unused_rep_cfg;
    assign unused_rep_cfg = (REP_DELAY > 0) ^ (REP_RATE > 0);
    assign rep = '0;
`endif

    always_comb begin
        press_d = rise | rep;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign led         = level_q;

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: random and directed stimulus against a history-based model,
// expected outputs queued per clock edge and checked by a separate monitor.
module tb_btn_debounce;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, led;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t exp_q[$];

    // model state: raw samples since the last reset, one per edge
    bit [NB-1:0] hist[$];
    int          k = 0;
    bit [NB-1:0] m_level = '0;
    int          lastchg[NB];
    int          t0[NB];

    btn_debounce #(
        .NBTN(NB),
        .DB_CYCLES(DB),
        .REP_DELAY(RD),
        .REP_RATE(RR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // value the second sync stage held just before edge j
    function automatic bit s2_at(int j, int ch);
        if (j - 2 < 1) return 1'b0;
        return hist[j-3][ch];
    endfunction

    task automatic model_step();
        exp_t e;
        bit   acc;
        int   d;
        e = '0;
        if (!rst_n) begin
            hist.delete();
            k = 0;
            m_level = '0;
            for (int c = 0; c < NB; c++) begin
                lastchg[c] = 0;
                t0[c] = 0;
            end
        end else begin
            k++;
            hist.push_back(btn);
            for (int c = 0; c < NB; c++) begin
                acc = (k - DB >= lastchg[c]);
                for (int j = k - DB + 1; j <= k; j++)
                    if (s2_at(j, c) == m_level[c]) acc = 1'b0;
                if (acc) begin
                    m_level[c] = ~m_level[c];
                    lastchg[c] = k;
                    if (m_level[c]) begin
                        e.press[c] = 1'b1;
                        t0[c] = k;
                    end else begin
                        e.rel[c] = 1'b1;
                    end
                end else if (REP_ON && m_level[c]) begin
                    d = k - t0[c];
                    if (d == RD || (d > RD && (d - RD) % RR == 0))
                        e.press[c] = 1'b1;
                end
            end
            e.level = m_level;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [NB-1:0] b, input logic r);
        logic was;
        @(negedge clk);
        was   = rst_n;
        btn   = b;
        rst_n = r;
        model_step();
        if (was && !r) begin
            #1;
            chk("rst_level", btn_level, '0);
            chk("rst_press", btn_press, '0);
            chk("rst_release", btn_release, '0);
        end
    endtask

    task automatic hold(input logic [NB-1:0] b, input int n);
        for (int i = 0; i < n; i++) cyc(b, 1'b1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("level", btn_level, e.level);
                chk("press", btn_press, e.press);
                chk("release", btn_release, e.rel);
                chk("led", led, e.level);
                chk("press_and_release", btn_press & btn_release, '0);
            end
        end
    end

    initial begin
        logic [NB-1:0] rb;
        int            left[NB];
        for (int i = 0; i < 4; i++) cyc(4'hF, 1'b0);
        hold(4'hF, 10);
        hold(4'h0, 10);
        for (int i = 0; i < 7; i++) begin
            rb = '0;
            rb[0] = (i == 3 || i == 6) ? 1'b0 : 1'b1;
            cyc(rb, 1'b1);
        end
        hold(4'h0, 8);
        hold(4'b0010, 20);
        hold(4'h0, 10);
        hold(4'b1100, 10);
        hold(4'h0, 10);
        hold(4'b0001, 3);
        cyc(4'b0001, 1'b0);
        hold(4'b0001, 10);
        hold(4'h0, 10);
        hold(4'b0001, 60);
        hold(4'h0, 10);
        rb = '0;
        for (int c = 0; c < NB; c++) left[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (left[c] == 0) begin
                    rb[c] = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ?
                              int'($urandom_range(20, 40)) :
                              int'($urandom_range(1, 8));
                end
                left[c]--;
            end
            cyc(rb, ($urandom_range(0, 499) != 0));
        end
        hold(4'h0, 10);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
